// File: rtl/tmr_mon_pkg.sv
// Shared state type and saturating-counter helper for the TMR vote monitor.
package tmr_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } mon_state_t;

    localparam int MAX_CNT_WIDTH = 32;
    localparam int NUM_CNT       = 4;
    localparam int IDX_A         = 0;
    localparam int IDX_B         = 1;
    localparam int IDX_C         = 2;
    localparam int IDX_M         = 3;

    // Increment a counter that is `width` bits wide, sticking at its all-ones value.
    function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
        input logic [MAX_CNT_WIDTH-1:0] count,
        input int unsigned              width
    );
        logic [MAX_CNT_WIDTH-1:0] limit;
        limit = (MAX_CNT_WIDTH'(1) << width) - MAX_CNT_WIDTH'(1);
        return (count >= limit) ? count : count + MAX_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tmr_vote_monitor_voter.sv
// Bitwise two-out-of-three majority of three redundant words.
module majorityVoter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] maj
);

    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_vote_monitor.sv
// Monitors a triplicated word against its majority vote, counts per-copy upsets
// and hands the counts to slow control through a req/valid/ack snapshot.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 en,
    output logic [WIDTH-1:0]     voted,
    output logic                 errA,
    output logic                 errB,
    output logic                 errC,
    output logic                 errMulti,
    output logic                 sticky,
    input  logic                 rd_req,
    output logic                 rd_valid,
    input  logic                 rd_ack,
    output logic [CNT_WIDTH-1:0] cntA,
    output logic [CNT_WIDTH-1:0] cntB,
    output logic [CNT_WIDTH-1:0] cntC,
    output logic [CNT_WIDTH-1:0] cntMulti
);

    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;
    logic [WIDTH-1:0] q_c;
    logic [WIDTH-1:0] maj;

    logic err_a_d;
    logic err_b_d;
    logic err_c_d;
    logic err_m_d;
    logic any_ev;

    logic [NUM_CNT-1:0]                ev;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] ic;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] ic_next;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;

    mon_state_t state;
    mon_state_t state_next;
    logic       snap;

    majorityVoter #(
        .WIDTH(WIDTH)
    ) u_voter (
        .a  (q_a),
        .b  (q_b),
        .c  (q_c),
        .maj(maj)
    );

    assign err_a_d = |(q_a ^ maj);
    assign err_b_d = |(q_b ^ maj);
    assign err_c_d = |(q_c ^ maj);
    assign err_m_d = (err_a_d & err_b_d) | (err_a_d & err_c_d) | (err_b_d & err_c_d);

    assign ev     = {err_m_d, err_c_d, err_b_d, err_a_d} & {NUM_CNT{en}};
    assign any_ev = |ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_a      <= '0;
            q_b      <= '0;
            q_c      <= '0;
            voted    <= '0;
            errA     <= 1'b0;
            errB     <= 1'b0;
            errC     <= 1'b0;
            errMulti <= 1'b0;
        end else begin
            q_a      <= inA;
            q_b      <= inB;
            q_c      <= inC;
            voted    <= maj;
            errA     <= err_a_d;
            errB     <= err_b_d;
            errC     <= err_c_d;
            errMulti <= err_m_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            ic_next[i] = ic[i];
            if (ev[i]) begin
                ic_next[i] = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(ic[i]), CNT_WIDTH));
            end
        end
    end

    // The snapshot takes the post-increment value so an event on the snapshot edge lands in it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ic     <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (snap) begin
            ic     <= '0;
            cnt    <= ic_next;
            sticky <= any_ev;
        end else begin
            ic     <= ic_next;
            sticky <= sticky | any_ev;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        snap       = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_next = HOLD;
                    snap       = 1'b1;
                end
            end
            HOLD: begin
                if (rd_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_valid = (state == HOLD);
    assign cntA     = cnt[IDX_A];
    assign cntB     = cnt[IDX_B];
    assign cntC     = cnt[IDX_C];
    assign cntMulti = cnt[IDX_M];

endmodule

// File: doc/tmr_vote_monitor.md
# tmr_vote_monitor

Single-domain companion to the triplicated register path. It takes the three redundant copies of a word plus a majority-voted result, reports per cycle which copy disagrees with the vote, and keeps saturating per-copy upset counters. Slow control reads and clears the counters through a req/valid/ack snapshot handshake. It sits downstream of the voters, next to the supervisor, and gives SEU statistics on nets that the voters would otherwise mask silently.

## Interface
- WIDTH, 8: bit width of each redundant copy.
- CNT_WIDTH, 16: width of each event counter.
- clk  in  1  single clock; every flop is clocked on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- inA, inB, inC  in  WIDTH  the three redundant copies.
- en  in  1  count enable. When 0, counters and sticky hold; voted and flags still update.
- voted  out  WIDTH  registered bitwise majority of the copies.
- errA, errB, errC  out  1  registered: that copy disagreed with the vote.
- errMulti  out  1  registered: two or more copies disagreed in the same cycle.
- sticky  out  1  set by any flagged error while en=1; cleared by a snapshot.
- rd_req  in  1  level request for a snapshot.
- rd_valid  out  1  snapshot outputs are stable and valid.
- rd_ack  in  1  consumer has taken the snapshot.
- cntA, cntB, cntC, cntMulti  out  CNT_WIDTH  snapshot values; hold until the next snapshot.

## Operation
- Stage 1: register inA/inB/inC into qA/qB/qC.
- Stage 2:
  - voted is the bitwise majority of qA/qB/qC.
  - errX = |(qX ^ maj).
  - errMulti = two or more of errA/errB/errC.
- The per-bit vote always corrects a single-bit disagreement. errMulti only means that different copies failed on different bits in the same cycle.
- Internal counters icA/icB/icC/icM:
  - Each increments by 1 on the same edge its flag is registered, if en=1.
  - Each saturates at 2^CNT_WIDTH-1 and never wraps.
- FSM states: IDLE, HOLD.
  - IDLE with rd_req=1: snapshot and go to HOLD.
  - HOLD with rd_ack=1: go to IDLE. rd_ack in IDLE is ignored.
- Snapshot edge:
  - cntX is loaded with the counter's next value, including any event registered on that same edge.
  - icX is cleared to 0. No event is ever lost or double-counted.
  - sticky is cleared, unless a new error is registered on that edge; in that case it stays set and the event is already in the snapshot.
- rd_req held high from HOLD through to IDLE starts a new snapshot on the first IDLE cycle.
- Reset values, all 0: qX, voted, all err flags, all ic and cnt values, sticky, rd_valid; FSM in IDLE.
- Reset asserted mid-operation, including in HOLD: everything returns to the reset values immediately and asynchronously. A pending snapshot is discarded.

## Timing
- inputs → voted and err flags: 2 cycles.
- An input error is first visible in icX on the edge where its err flag rises.
- rd_req sampled high in IDLE at edge N: rd_valid=1 and cnt values valid from edge N.
- rd_ack sampled high at edge M: rd_valid=0 from edge M.
- Earliest next snapshot: edge M+1.
- Minimum snapshot period: 2 cycles.
- No combinational path from any input to any output.

## Structure
- Package tmr_mon_pkg:
  - mon_state_t enum {IDLE, HOLD}.
  - function sat_inc(count, CNT_WIDTH).
- Sub-module: majorityVoter, instantiated once with WIDTH, for the stage-2 vote.
- Top level holds the stage-1 and stage-2 registers, counters and FSM. About 150–250 lines.

## Test plan
All scenarios use WIDTH=4, CNT_WIDTH=4.
- **Reset:** rstn=0 with random inputs → all outputs 0. Release, all copies 0xA for 5 cycles → voted=0xA from cycle 2, no flags.
- **Single-copy fault:**
  - Stimulus: inA=0x5, inB=inC=0xF for 3 cycles, en=1; then read.
  - Response: voted=0xF; errA=1 for exactly 3 cycles, starting 2 cycles after the stimulus; sticky=1.
  - Snapshot: cntA=3, cntB=cntC=cntMulti=0; sticky cleared.
- **Multi-copy fault:** inA=0x1, inB=0x2, inC=0x0 for 1 cycle → voted=0x0, errA=errB=errMulti=1, errC=0. Snapshot gives cntA=cntB=cntMulti=1.
- **Saturation and enable:**
  - 20 cycles of inB differing → cntB=15, no wrap.
  - Repeat with en=0 → cntB=0, sticky=0, errB still pulses.
- **Handshake edges:**
  - rd_req on the same edge an errC is registered → cntC includes that event; the next snapshot shows 0.
  - rd_req held through rd_ack → second snapshot starts one cycle after the ack.
  - rd_ack in IDLE → ignored.
- **Reset in HOLD:** rd_valid=1, then pulse rstn low mid-cycle → rd_valid and cnt values drop to 0 asynchronously; FSM in IDLE after release.
